// File: rtl/reg_mem_wb_multi_pkg.sv
// rtl/reg_mem_wb_multi_pkg.sv - shared widths, stall-vector layout and MEM/WB action decode
// Contents:
//   REG_ADDR_W / REG_DATA_W : default register address / data widths
//   STALL_W, STG_*          : stall-vector width and per-stage bit positions
//   wb_action_e, wb_action  : per-edge update decision for the MEM/WB register
package reg_mem_wb_multi_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam int STALL_W = 6;
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  typedef enum logic [1:0] {
    WB_ADVANCE = 2'd0,
    WB_HOLD    = 2'd1,
    WB_BUBBLE  = 2'd2,
    WB_FLUSH   = 2'd3
  } wb_action_e;

  // Flush beats every stall state; s_down only matters while this stage is stalled.
  function automatic wb_action_e wb_action(input logic flush,
                                           input logic s_here,
                                           input logic s_down);
    wb_action_e act;
    if (flush)        act = WB_FLUSH;
    else if (!s_here) act = WB_ADVANCE;
    else if (s_down)  act = WB_HOLD;
    else              act = WB_BUBBLE;
    return act;
  endfunction

endpackage

// File: rtl/wb_conflict_resolve.sv
// rtl/wb_conflict_resolve.sv - combinational write-enable arbitration for a writeback bundle
// Ports:
//   addr_i : per-channel destination address, channel i at [i*AW +: AW]
//   we_i   : per-channel raw write enable
//   we_o   : resolved enables; at most one channel per address, x0 optionally dropped
module wb_conflict_resolve
  import reg_mem_wb_multi_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int AW            = REG_ADDR_W,
  parameter bit ZERO_SUPPRESS = 1'b1
) (
  input  logic [NUM_CH*AW-1:0] addr_i,
  input  logic [NUM_CH-1:0]    we_i,
  output logic [NUM_CH-1:0]    we_o
);

  logic [NUM_CH-1:0] we_pre;

  always_comb begin
    we_pre = we_i;
    if (ZERO_SUPPRESS) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (addr_i[i*AW +: AW] == '0) we_pre[i] = 1'b0;
      end
    end
  end

  // A channel loses if any later channel still writes the same address, so the
  // last channel in program order survives; comparing against the pre-conflict
  // enables keeps a three-way tie down to exactly one winner.
  always_comb begin
    we_o = we_pre;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int j = i + 1; j < NUM_CH; j++) begin
        if (we_pre[j] && (addr_i[j*AW +: AW] == addr_i[i*AW +: AW])) we_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_mem_wb_multi.sv
// rtl/reg_mem_wb_multi.sv - multi-channel MEM/WB pipeline register with flush, bubble count
// Ports:
//   clk, rst       : rising-edge clock, asynchronous active-high reset
//   stall          : stall vector; bit STAGE_IDX is this stage, STAGE_IDX+1 downstream
//   flush          : squash the held bundle
//   mem_reg_waddr  : per-channel address from MEM, channel i at [i*AW +: AW]
//   mem_we         : per-channel write enable from MEM
//   mem_reg_wdata  : per-channel data from MEM, channel i at [i*DW +: DW]
//   wb_reg_waddr   : registered addresses
//   wb_we          : registered, conflict-resolved enables
//   wb_reg_wdata   : registered data
//   wb_valid       : bundle is real, not a bubble/flush
//   bubble_cnt     : saturating count of inserted bubbles
module reg_mem_wb_multi
  import reg_mem_wb_multi_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int AW            = REG_ADDR_W,
  parameter int DW            = REG_DATA_W,
  parameter int STALL_W       = reg_mem_wb_multi_pkg::STALL_W,
  parameter int STAGE_IDX     = STG_MEM,
  parameter bit ZERO_SUPPRESS = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic [NUM_CH*AW-1:0] mem_reg_waddr,
  input  logic [NUM_CH-1:0]    mem_we,
  input  logic [NUM_CH*DW-1:0] mem_reg_wdata,
  output logic [NUM_CH*AW-1:0] wb_reg_waddr,
  output logic [NUM_CH-1:0]    wb_we,
  output logic [NUM_CH*DW-1:0] wb_reg_wdata,
  output logic                 wb_valid,
  output logic [CNT_W-1:0]     bubble_cnt
);

  logic [NUM_CH*AW-1:0] waddr_q, waddr_d;
  logic [NUM_CH-1:0]    we_q, we_d;
  logic [NUM_CH*DW-1:0] wdata_q, wdata_d;
  logic                 valid_q, valid_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [NUM_CH-1:0]    we_resolved;
  wb_action_e           action;

  wb_conflict_resolve #(
    .NUM_CH       (NUM_CH),
    .AW           (AW),
    .ZERO_SUPPRESS(ZERO_SUPPRESS)
  ) u_resolve (
    .addr_i(mem_reg_waddr),
    .we_i  (mem_we),
    .we_o  (we_resolved)
  );

  assign action = wb_action(flush, stall[STAGE_IDX], stall[STAGE_IDX+1]);

  always_comb begin
    waddr_d = waddr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (action)
      WB_ADVANCE: begin
        waddr_d = mem_reg_waddr;
        we_d    = we_resolved;
        wdata_d = mem_reg_wdata;
        valid_d = 1'b1;
      end
      WB_HOLD: ;
      WB_BUBBLE: begin
        waddr_d = '0;
        we_d    = '0;
        wdata_d = '0;
        valid_d = 1'b0;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end
      WB_FLUSH: begin
        // Flushes are not pipeline bubbles, so the counter is left alone.
        waddr_d = '0;
        we_d    = '0;
        wdata_d = '0;
        valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr_q <= '0;
      we_q    <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      waddr_q <= waddr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_reg_waddr = waddr_q;
  assign wb_we        = we_q;
  assign wb_reg_wdata = wdata_q;
  assign wb_valid     = valid_q;
  assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_reg_mem_wb_multi.sv
// tb/tb_reg_mem_wb_multi.sv - scoreboard bench for reg_mem_wb_multi
module tb_reg_mem_wb_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic [9:0]  mem_reg_waddr = '0;
  logic [1:0]  mem_we = '0;
  logic [63:0] mem_reg_wdata = '0;

  logic [9:0]  wb_reg_waddr, s_waddr;
  logic [1:0]  wb_we, s_we;
  logic [63:0] wb_reg_wdata, s_wdata;
  logic        wb_valid, s_valid;
  logic [15:0] bubble_cnt;
  logic [2:0]  s_cnt;

  always #5 clk = ~clk;

  reg_mem_wb_multi dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_reg_waddr(mem_reg_waddr), .mem_we(mem_we), .mem_reg_wdata(mem_reg_wdata),
    .wb_reg_waddr(wb_reg_waddr), .wb_we(wb_we), .wb_reg_wdata(wb_reg_wdata),
    .wb_valid(wb_valid), .bubble_cnt(bubble_cnt)
  );

  reg_mem_wb_multi #(.CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_reg_waddr(mem_reg_waddr), .mem_we(mem_we), .mem_reg_wdata(mem_reg_wdata),
    .wb_reg_waddr(s_waddr), .wb_we(s_we), .wb_reg_wdata(s_wdata),
    .wb_valid(s_valid), .bubble_cnt(s_cnt)
  );

  typedef struct {
    string       name;
    logic [9:0]  waddr;
    logic [1:0]  we;
    logic [63:0] wdata;
    logic        valid;
    logic [15:0] cnt;
    logic [2:0]  cnt3;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;
  int   exp_cnt3 = 0;

  task automatic chk(input string nm, input string field, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s.%s actual=%h required=%h", nm, field, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "waddr", 64'(wb_reg_waddr), 64'(e.waddr));
      chk(e.name, "we",    64'(wb_we),        64'(e.we));
      chk(e.name, "wdata", wb_reg_wdata,      e.wdata);
      chk(e.name, "valid", 64'(wb_valid),     64'(e.valid));
      chk(e.name, "cnt",   64'(bubble_cnt),   64'(e.cnt));
      chk(e.name, "cnt3",  64'(s_cnt),        64'(e.cnt3));
    end
  end

  task automatic push(input string nm, input logic [9:0] ea, input logic [1:0] ew,
                      input logic [63:0] ed, input logic ev);
    exp_t e;
    e.name = nm; e.waddr = ea; e.we = ew; e.wdata = ed; e.valid = ev;
    e.cnt = 16'(exp_cnt); e.cnt3 = 3'(exp_cnt3);
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs; expectation is what the outputs show after the next posedge.
  task automatic step(input string nm, input logic [5:0] st, input logic fl,
                      input logic [9:0] a, input logic [1:0] w, input logic [63:0] d,
                      input logic [9:0] ea, input logic [1:0] ew, input logic [63:0] ed,
                      input logic ev);
    stall = st; flush = fl; mem_reg_waddr = a; mem_we = w; mem_reg_wdata = d;
    if (!fl && st[4] && !st[5]) begin
      if (exp_cnt < 65535) exp_cnt++;
      if (exp_cnt3 < 7) exp_cnt3++;
    end
    push(nm, ea, ew, ed, ev);
    @(negedge clk);
    #1;
  endtask

  // Reset asserted between edges: outputs must clear before any further clock edge.
  task automatic mid_reset(input string nm);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_cnt = 0;
    exp_cnt3 = 0;
    push(nm, '0, '0, '0, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  localparam logic [5:0] ADV  = 6'b000000;
  localparam logic [5:0] DOWN = 6'b100000;
  localparam logic [5:0] HOLD = 6'b110000;
  localparam logic [5:0] BUB  = 6'b010000;

  initial begin
    push("reset_init", '0, '0, '0, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;

    step("load", ADV, 0, {5'd7, 5'd3}, 2'b11, {32'hBB, 32'hAA},
         {5'd7, 5'd3}, 2'b11, {32'hBB, 32'hAA}, 1);
    mid_reset("reset_midop");

    step("advance", ADV, 0, {5'd9, 5'd5}, 2'b11, {32'h2222, 32'h1111},
         {5'd9, 5'd5}, 2'b11, {32'h2222, 32'h1111}, 1);
    step("conflict", DOWN, 0, {5'd12, 5'd12}, 2'b11, {32'h44, 32'h33},
         {5'd12, 5'd12}, 2'b10, {32'h44, 32'h33}, 1);
    step("x0", ADV, 0, {5'd4, 5'd0}, 2'b01, {32'h66, 32'h55},
         {5'd4, 5'd0}, 2'b00, {32'h66, 32'h55}, 1);
    step("dis_hi", ADV, 0, {5'd8, 5'd8}, 2'b01, {32'h78, 32'h77},
         {5'd8, 5'd8}, 2'b01, {32'h78, 32'h77}, 1);
    step("preload", ADV, 0, {5'd2, 5'd1}, 2'b11, {32'hB2, 32'hA1},
         {5'd2, 5'd1}, 2'b11, {32'hB2, 32'hA1}, 1);

    for (int i = 0; i < 3; i++)
      step("hold", HOLD, 0, {5'd30, 5'd31}, 2'b11, {32'hDEAD, 32'hBEEF},
           {5'd2, 5'd1}, 2'b11, {32'hB2, 32'hA1}, 1);
    for (int i = 0; i < 3; i++)
      step("bubble", BUB, 0, {5'd30, 5'd31}, 2'b11, {32'hDEAD, 32'hBEEF},
           '0, '0, '0, 0);

    step("flush_bub", BUB, 1, {5'd30, 5'd31}, 2'b11, {32'hDEAD, 32'hBEEF},
         '0, '0, '0, 0);
    step("reload", ADV, 0, {5'd2, 5'd1}, 2'b11, {32'hB2, 32'hA1},
         {5'd2, 5'd1}, 2'b11, {32'hB2, 32'hA1}, 1);
    step("flush_hold", HOLD, 1, {5'd30, 5'd31}, 2'b11, {32'hDEAD, 32'hBEEF},
         '0, '0, '0, 0);

    for (int i = 0; i < 7; i++)
      step("sat", BUB, 0, {5'd30, 5'd31}, 2'b11, {32'hDEAD, 32'hBEEF},
           '0, '0, '0, 0);

    mid_reset("reset_end");
    step("post_reset", ADV, 0, {5'd17, 5'd17}, 2'b11, {32'h5A5A, 32'hA5A5},
         {5'd17, 5'd17}, 2'b10, {32'h5A5A, 32'hA5A5}, 1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_mem_wb_multi.md
Name: reg_mem_wb_multi

Overview:
- Parametrised successor to the single-channel MEM/WB pipeline register.
- Carries NUM_CH independent register-writeback channels from MEM to WB.
- Extends the stall-vector bubble rule with:
  - an explicit flush input,
  - intra-bundle write-conflict resolution,
  - x0 write suppression,
  - a registered valid flag,
  - a saturating bubble-cycle performance counter.
- Sits between the MEM stage and the register file write ports.

Parameters:
- NUM_CH, 2, number of writeback channels (1..4)
- AW, 5, register address width per channel
- DW, 32, data width per channel
- STALL_W, 6, width of the stall vector
- STAGE_IDX, 4, stall bit owned by this stage; STAGE_IDX+1 is the downstream bit (must be < STALL_W)
- ZERO_SUPPRESS, 1, when 1, writes to address 0 are dropped at capture
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall  in  STALL_W  pipeline stall vector from the stall controller
- flush  in  1  squash the stage contents (exception/redirect)
- mem_reg_waddr  in  NUM_CH*AW  per-channel destination address, channel i at [i*AW +: AW]
- mem_we  in  NUM_CH  per-channel write enable
- mem_reg_wdata  in  NUM_CH*DW  per-channel write data, channel i at [i*DW +: DW]
- wb_reg_waddr  out  NUM_CH*AW  registered addresses
- wb_we  out  NUM_CH  registered, conflict-resolved write enables
- wb_reg_wdata  out  NUM_CH*DW  registered data
- wb_valid  out  1  stage holds a real (non-bubble) bundle
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (async, active-high): all outputs 0 immediately, including bubble_cnt. The held bundle is lost; first capture happens on the first posedge after rst deasserts.
- Define s_here = stall[STAGE_IDX] and s_down = stall[STAGE_IDX+1].
- Per-posedge priority, highest first:
  1. flush=1:
     - wb_we, wb_reg_waddr, wb_reg_wdata, wb_valid <= 0.
     - bubble_cnt unchanged.
     - Flush overrides any stall state.
  2. s_here && !s_down (bubble):
     - same zeroing as flush.
     - bubble_cnt <= bubble_cnt+1, saturating at all-ones (no wrap).
  3. s_here && s_down (hold): all registers keep their values.
  4. !s_here (advance):
     - wb_reg_waddr and wb_reg_wdata <= inputs, unmodified.
     - wb_valid <= 1.
     - wb_we <= resolved enables (below).
- Enable resolution (combinational, applied only at capture):
  - Start: we_r[i] = mem_we[i].
  - If ZERO_SUPPRESS and mem_reg_waddr[i]==0: we_r[i]=0.
  - Conflict: for each i, if some j>i has we_r[j]=1 and the same address, then we_r[i]=0. The highest-index channel wins, matching program order within the bundle.
  - Three-way same-address conflicts leave exactly one enable set.
  - Disabled channels still capture their addr/data, which are unused.
- Latency: one cycle from capture to output.
- No combinational path from any input to any output.
- NUM_CH=1, ZERO_SUPPRESS=0 reproduces the single-channel block exactly; wb_valid and bubble_cnt are extra.
- s_down is ignored when s_here=0.
- Simultaneous flush and bubble: flush wins, so bubble_cnt does not increment.

Decomposition:
- Shared package/defines: AW/DW defaults (RegAddrBus/RegBus widths) and the stall-vector width and stage index constants for IF..WB.
- One natural sub-module: wb_conflict_resolve. Purely combinational; inputs addr/we vectors, output resolved we. Reusable by the register file for its write-port arbitration check.
- Everything else stays flat in this module.

Test Plan:
- Reset mid-operation: load bundle (ch0 addr 3 we=1 data 0xAA, ch1 addr 7 we=1 data 0xBB), assert rst between edges -> all outputs 0 at once, bubble_cnt=0, wb_valid=0.
- Advance: stall=6'b000000, ch0 (addr 5, we 1, 0x1111), ch1 (addr 9, we 1, 0x2222) -> next cycle wb_we=2'b11, addrs 5/9, data 0x1111/0x2222, wb_valid=1.
- Conflict and x0:
  - ch0 and ch1 both addr 12, we=1 -> wb_we=2'b10.
  - ch0 addr 0 we=1, ch1 we=0, ZERO_SUPPRESS=1 -> wb_we=2'b00, wb_valid=1.
- Hold vs bubble:
  - stall=6'b110000 for 3 cycles -> outputs frozen, bubble_cnt unchanged.
  - stall=6'b010000 -> outputs zero, bubble_cnt +1 per cycle (3 cycles -> 3).
- Flush priority: flush=1 with stall=6'b010000 -> outputs zero, bubble_cnt unchanged. Flush=1 with stall=6'b110000 -> outputs zero despite hold.
- Saturation: CNT_W=3, 10 consecutive bubble cycles -> bubble_cnt stops at 7 and stays 7.
